pending_decoder: RTL and testbench

PENDING_DECODER -- requirements
Module: pending_decoder

---
 rtl/pending_decoder.sv | 129 ++++++++++++
 tb/tb_pending_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pending_decoder.sv
// Pending-bit tracker: encoded set/clear requests update a registered bitmap,
// with population count, a one-hot pulse for new sets, and sticky error flags.
module pending_decoder #(
    parameter  int WIDTH          = 4,
    parameter  int CLEAR_PRIORITY = 0,
    localparam int IW             = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CW             = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             set_valid_i,
    input  logic [IW-1:0]    set_index_i,
    output logic             set_ready_o,
    input  logic             clr_valid_i,
    input  logic [IW-1:0]    clr_index_i,
    input  logic             clr_all_i,
    output logic [WIDTH-1:0] pending_o,
    output logic             pending_any_o,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] set_onehot_o,
    output logic             dup_o,
    output logic             range_err_o
);

    localparam logic [IW:0] LIMIT = (IW + 1)'(WIDTH);

    // Indices at or beyond WIDTH never match a bit, so decoding also gates range.
    function automatic logic [WIDTH-1:0] f_decode(input logic [IW-1:0] idx, input logic en);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < WIDTH; i++) begin
            v[i] = en && (idx == IW'(i));
        end
        return v;
    endfunction

    function automatic logic [CW-1:0] f_popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    logic [WIDTH-1:0] r_pending;
    logic             r_any;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_onehot;
    logic             r_dup;
    logic             r_range_err;

    logic             w_set_acc;
    logic             w_set_in_range;
    logic             w_clr_in_range;
    logic [WIDTH-1:0] w_set_mask;
    logic [WIDTH-1:0] w_clr_mask;
    logic             w_dup_hit;
    logic             w_range_hit;
    logic [WIDTH-1:0] w_pending_nxt;
    logic [WIDTH-1:0] w_onehot_nxt;
    logic             w_dup_nxt;
    logic             w_range_err_nxt;

    assign set_ready_o    = !clr_all_i;
    assign w_set_acc      = set_valid_i && !clr_all_i;
    assign w_set_in_range = ({1'b0, set_index_i} < LIMIT);
    assign w_clr_in_range = ({1'b0, clr_index_i} < LIMIT);
    assign w_set_mask     = f_decode(set_index_i, w_set_acc);
    assign w_clr_mask     = f_decode(clr_index_i, clr_valid_i);

    // A set on a bit that stays pending (not cleared this cycle) is a duplicate.
    assign w_dup_hit   = |(w_set_mask & r_pending & ~w_clr_mask);
    assign w_range_hit = (w_set_acc && !w_set_in_range) || (clr_valid_i && !w_clr_in_range);

    // Next-state computation for the bitmap, pulse and sticky flags.
    always_comb begin
        w_pending_nxt   = r_pending;
        w_onehot_nxt    = '0;
        w_dup_nxt       = r_dup;
        w_range_err_nxt = r_range_err;
        if (clr_all_i) begin
            w_pending_nxt   = '0;
            w_onehot_nxt    = '0;
            w_dup_nxt       = 1'b0;
            w_range_err_nxt = 1'b0;
        end else begin
            if (CLEAR_PRIORITY != 0) begin
                w_pending_nxt = (r_pending | w_set_mask) & ~w_clr_mask;
            end else begin
                w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
            end
            if (w_dup_hit) begin
                w_onehot_nxt = '0;
            end else begin
                w_onehot_nxt = w_set_mask;
            end
            w_dup_nxt       = r_dup | w_dup_hit;
            w_range_err_nxt = r_range_err | w_range_hit;
        end
    end

    // Output state registers; count and any derive from the same next bitmap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending   <= '0;
            r_any       <= 1'b0;
            r_count     <= '0;
            r_onehot    <= '0;
            r_dup       <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_pending   <= w_pending_nxt;
            r_any       <= |w_pending_nxt;
            r_count     <= f_popcount(w_pending_nxt);
            r_onehot    <= w_onehot_nxt;
            r_dup       <= w_dup_nxt;
            r_range_err <= w_range_err_nxt;
        end
    end

    assign pending_o     = r_pending;
    assign pending_any_o = r_any;
    assign count_o       = r_count;
    assign set_onehot_o  = r_onehot;
    assign dup_o         = r_dup;
    assign range_err_o   = r_range_err;

endmodule

// File: tb/tb_pending_decoder.sv
// Scoreboard bench: two instances (set-priority and clear-priority) share random
// stimulus; a per-instance reference model queues expected outputs per edge.
module tb_pending_decoder;

    typedef struct packed {
        logic [4:0] pend;
        logic [2:0] cnt;
        logic       any;
        logic [4:0] oh;
        logic       dup;
        logic       err;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       set_valid_i = 1'b0;
    logic [2:0] set_index_i = 3'd0;
    logic       clr_valid_i = 1'b0;
    logic [2:0] clr_index_i = 3'd0;
    logic       clr_all_i = 1'b0;

    logic       rdy0, any0, dup0, err0, rdy1, any1, dup1, err1;
    logic [4:0] pend0, oh0, pend1, oh1;
    logic [2:0] cnt0, cnt1;

    int checks = 0;
    int failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    bit mp [2][5];
    bit mdup [2];
    bit merr [2];

    always #5 clk_i = ~clk_i;

    pending_decoder #(.WIDTH(5), .CLEAR_PRIORITY(0)) u_dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .set_valid_i(set_valid_i), .set_index_i(set_index_i), .set_ready_o(rdy0),
        .clr_valid_i(clr_valid_i), .clr_index_i(clr_index_i), .clr_all_i(clr_all_i),
        .pending_o(pend0), .pending_any_o(any0), .count_o(cnt0),
        .set_onehot_o(oh0), .dup_o(dup0), .range_err_o(err0)
    );

    pending_decoder #(.WIDTH(5), .CLEAR_PRIORITY(1)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .set_valid_i(set_valid_i), .set_index_i(set_index_i), .set_ready_o(rdy1),
        .clr_valid_i(clr_valid_i), .clr_index_i(clr_index_i), .clr_all_i(clr_all_i),
        .pending_o(pend1), .pending_any_o(any1), .count_o(cnt1),
        .set_onehot_o(oh1), .dup_o(dup1), .range_err_o(err1)
    );

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h", name, d, act, exp);
        end
    endtask

    task automatic check_outs(input int d, input exp_t e);
        if (d == 0) begin
            chk("pending", 0, 32'(pend0), 32'(e.pend));
            chk("count", 0, 32'(cnt0), 32'(e.cnt));
            chk("any", 0, 32'(any0), 32'(e.any));
            chk("onehot", 0, 32'(oh0), 32'(e.oh));
            chk("dup", 0, 32'(dup0), 32'(e.dup));
            chk("range_err", 0, 32'(err0), 32'(e.err));
        end else begin
            chk("pending", 1, 32'(pend1), 32'(e.pend));
            chk("count", 1, 32'(cnt1), 32'(e.cnt));
            chk("any", 1, 32'(any1), 32'(e.any));
            chk("onehot", 1, 32'(oh1), 32'(e.oh));
            chk("dup", 1, 32'(dup1), 32'(e.dup));
            chk("range_err", 1, 32'(err1), 32'(e.err));
        end
    endtask

    // Reference model: applies the request rules to a plain bit array.
    task automatic model_step(input int d, input bit clear_wins, output exp_t e);
        int si, ci, n;
        bit set_ok, clr_ok;
        si = int'(set_index_i);
        ci = int'(clr_index_i);
        e = '0;
        if (clr_all_i) begin
            for (int i = 0; i < 5; i++) mp[d][i] = 1'b0;
            mdup[d] = 1'b0;
            merr[d] = 1'b0;
        end else begin
            set_ok = set_valid_i && (si < 5);
            clr_ok = clr_valid_i && (ci < 5);
            if ((set_valid_i && si >= 5) || (clr_valid_i && ci >= 5)) merr[d] = 1'b1;
            if (set_ok) begin
                if (mp[d][si] && !(clr_ok && ci == si)) mdup[d] = 1'b1;
                else e.oh = 5'(1 << si);
            end
            if (set_ok && clr_ok && si == ci) begin
                mp[d][si] = !clear_wins;
            end else begin
                if (clr_ok) mp[d][ci] = 1'b0;
                if (set_ok) mp[d][si] = 1'b1;
            end
        end
        n = 0;
        for (int i = 0; i < 5; i++) begin
            e.pend[i] = mp[d][i];
            n += int'(mp[d][i]);
        end
        e.cnt = 3'(n);
        e.any = (n > 0);
        e.dup = mdup[d];
        e.err = merr[d];
    endtask

    task automatic drive(input bit sv, input int si, input bit cv, input int ci, input bit ca);
        set_valid_i = sv;
        set_index_i = 3'(si);
        clr_valid_i = cv;
        clr_index_i = 3'(ci);
        clr_all_i   = ca;
        #1;
        chk("set_ready", 0, 32'(rdy0), 32'(!ca));
        chk("set_ready", 1, 32'(rdy1), 32'(!ca));
    endtask

    task automatic step();
        exp_t e0, e1;
        @(posedge clk_i);
        model_step(0, 1'b0, e0);
        model_step(1, 1'b1, e1);
        q0.push_back(e0);
        q1.push_back(e1);
        #1;
    endtask

    task automatic cyc(input bit sv, input int si, input bit cv, input int ci, input bit ca);
        drive(sv, si, cv, ci, ca);
        step();
    endtask

    // Monitor: outputs are registered every edge, so one expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check_outs(0, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check_outs(1, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int si, ci;
        bit sv, cv, ca;
        // Requests held during reset must be ignored until rst_ni rises.
        drive(1'b1, 2, 1'b0, 0, 1'b0);
        #1;
        check_outs(0, '0);
        check_outs(1, '0);
        #6;
        check_outs(0, '0);
        #4;
        rst_ni = 1'b1;
        step();
        cyc(1'b0, 0, 1'b0, 0, 1'b1);

        cyc(1'b1, 0, 1'b0, 0, 1'b0);
        cyc(1'b1, 4, 1'b0, 0, 1'b0);
        cyc(1'b1, 2, 1'b0, 0, 1'b0);
        cyc(1'b1, 3, 1'b0, 0, 1'b0);
        cyc(1'b1, 3, 1'b1, 3, 1'b0);
        cyc(1'b1, 1, 1'b1, 0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1, 1'b0);
        cyc(1'b0, 0, 1'b1, 1, 1'b0);

        cyc(1'b1, 6, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b1, 7, 1'b0);
        cyc(1'b0, 0, 1'b0, 0, 1'b1);
        cyc(1'b1, 1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1, 1'b0, 0, 1'b0);
        cyc(1'b1, 3, 1'b0, 0, 1'b1);
        cyc(1'b1, 5, 1'b1, 6, 1'b1);

        for (int k = 0; k < 400; k++) begin
            sv = ($urandom_range(0, 3) != 0);
            si = $urandom_range(0, 7);
            cv = ($urandom_range(0, 1) == 1);
            ci = ($urandom_range(0, 3) == 0) ? si : $urandom_range(0, 7);
            ca = ($urandom_range(0, 15) == 0);
            cyc(sv, si, cv, ci, ca);
        end

        cyc(1'b0, 0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, i, 1'b0, 0, 1'b0);
        drive(1'b1, 2, 1'b1, 4, 1'b0);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check_outs(0, '0);
        check_outs(1, '0);
        chk("queue_drained", 0, 32'(q0.size()), 32'd0);
        chk("queue_drained", 1, 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
